// File: rtl/mul_hilo_ctrl.sv
// HI/LO register file and MULT sequencer for an external multi-cycle multiplier.
// Define MUL_HILO_OVF_TRAP_EN to raise ovf_trap when the multiplier flags an exception.
module mul_hilo_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_mult,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] mul_A,
    output logic [31:0] mul_B,
    output logic        mul_do,
    input  logic        mul_ready,
    input  logic        mul_exception,
    input  logic [63:0] mul_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_rdata,
    output logic        stall,
    output logic        busy,
    output logic        timeout_err,
    output logic        ovf_trap
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StWrite  = 2'd3
    } state_t;

    // Last WAIT count value before the operation is abandoned.
    localparam logic [5:0] TimeoutLast = 6'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_timeout;
    logic        w_accept;
    logic        w_any_req;

    assign w_accept  = (r_state == StIdle) & start_mult;
    assign w_any_req = start_mult | mfhi | mflo | mthi | mtlo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A ready flag seen in LAUNCH is stale from the previous product and is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_mult) begin
                    w_state_nxt = StLaunch;
                end
            end
            StLaunch: begin
                w_state_nxt = StWait;
                w_cnt_nxt   = '0;
            end
            StWait: begin
                if (mul_ready) begin
                    w_state_nxt = StWrite;
                end else if (r_cnt == TimeoutLast) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            StWrite: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_accept) begin
            r_op_a <= rs_val;
            r_op_b <= rt_val;
        end
    end

    // Moves only take effect in IDLE; a MULT accepted on the same edge overwrites later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == StWrite) begin
            r_hi <= mul_result[63:32];
            r_lo <= mul_result[31:0];
        end else if (r_state == StIdle) begin
            if (mthi) begin
                r_hi <= wdata;
            end
            if (mtlo) begin
                r_lo <= wdata;
            end
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (mfhi) begin
            hilo_rdata = r_hi;
        end else if (mflo) begin
            hilo_rdata = r_lo;
        end
    end

    assign mul_A       = r_op_a;
    assign mul_B       = r_op_b;
    assign mul_do      = (r_state == StLaunch);
    assign busy        = (r_state != StIdle);
    assign stall       = w_any_req & busy;
    assign timeout_err = w_timeout;
    assign hi          = r_hi;
    assign lo          = r_lo;

`ifdef MUL_HILO_OVF_TRAP_EN
    assign ovf_trap = (r_state == StWrite) & mul_exception;
`else
    logic w_unused_exc;
    assign w_unused_exc = mul_exception;
    assign ovf_trap     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: a cycle-indexed reference model plus literal expectations.
module tb_mul_hilo_ctrl;

    localparam int unsigned TO = 40;
`ifdef MUL_HILO_OVF_TRAP_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_mult = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mfhi = 1'b0, mflo = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] mul_A, mul_B;
    logic        mul_do;
    logic        mul_ready = 1'b0;
    logic        mul_exception = 1'b0;
    logic [63:0] mul_result = '0;
    logic [31:0] hi, lo, hilo_rdata;
    logic        stall, busy, timeout_err, ovf_trap;

    int checks = 0;
    int failures = 0;

    mul_hilo_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .rs_val(rs_val), .rt_val(rt_val),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .mul_A(mul_A), .mul_B(mul_B), .mul_do(mul_do), .mul_ready(mul_ready),
        .mul_exception(mul_exception), .mul_result(mul_result), .hi(hi), .lo(lo),
        .hilo_rdata(hilo_rdata), .stall(stall), .busy(busy), .timeout_err(timeout_err),
        .ovf_trap(ovf_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // External multiplier: product ready mm_lat cycles after the strobe edge (0 = never).
    int          mm_lat = 3;
    bit          mm_exc = 1'b0;
    int          mm_cnt = 0;
    logic [63:0] mm_prod = '0;
    always @(posedge clk) begin
        if (mul_do) begin
            mm_cnt        <= mm_lat;
            mm_prod       <= 64'(longint'($signed(mul_A)) * longint'($signed(mul_B)));
            mul_ready     <= 1'b0;
            mul_exception <= 1'b0;
        end else if (mm_cnt == 1) begin
            mm_cnt        <= 0;
            mul_ready     <= 1'b1;
            mul_result    <= mm_prod;
            mul_exception <= mm_exc;
        end else if (mm_cnt > 1) begin
            mm_cnt <= mm_cnt - 1;
        end
    end

    // Reference model indexed by cycle number: an op accepted in cycle acc launches in
    // acc+1, waits from acc+2, writes the cycle after ready, or times out at acc+1+TO.
    int unsigned cyc = 0, acc = 0, wr_at = 0, p = 0;
    bit          op = 1'b0, wr_set = 1'b0;
    logic [31:0] ea = '0, eb = '0, e_hi = '0, e_lo = '0, x_rd;
    logic [63:0] prod;
    bit          x_do, x_to, x_ovf, x_wr;
    int          do_cnt = 0, to_cnt = 0, ovf_cnt = 0;

    always @(negedge clk) begin
        if (mul_do) do_cnt++;
        if (timeout_err) to_cnt++;
        if (ovf_trap) ovf_cnt++;
        if (!rst_n) begin
            op = 1'b0; wr_set = 1'b0; e_hi = '0; e_lo = '0;
            chk("rst_hi", 64'(hi), 64'd0);
            chk("rst_lo", 64'(lo), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_stall", 64'(stall), 64'd0);
            chk("rst_do", 64'(mul_do), 64'd0);
            chk("rst_to", 64'(timeout_err), 64'd0);
            chk("rst_ovf", 64'(ovf_trap), 64'd0);
            chk("rst_opa", 64'(mul_A), 64'd0);
            chk("rst_opb", 64'(mul_B), 64'd0);
        end else begin
            p     = cyc - acc;
            x_wr  = op && wr_set && (cyc == wr_at);
            x_do  = op && (p == 1);
            x_to  = op && !wr_set && (p == TO + 1) && !mul_ready;
            x_ovf = OvfEn && x_wr && mul_exception;
            x_rd  = mfhi ? e_hi : (mflo ? e_lo : 32'd0);
            chk("m_hi", 64'(hi), 64'(e_hi));
            chk("m_lo", 64'(lo), 64'(e_lo));
            chk("m_busy", 64'(busy), 64'(op));
            chk("m_do", 64'(mul_do), 64'(x_do));
            chk("m_to", 64'(timeout_err), 64'(x_to));
            chk("m_ovf", 64'(ovf_trap), 64'(x_ovf));
            chk("m_rdata", 64'(hilo_rdata), 64'(x_rd));
            chk("m_stall", 64'(stall),
                64'((start_mult | mfhi | mflo | mthi | mtlo) & op));
            if (op) begin
                chk("m_opa", 64'(mul_A), 64'(ea));
                chk("m_opb", 64'(mul_B), 64'(eb));
            end
            if (op) begin
                if (x_wr) begin
                    prod = 64'(longint'($signed(ea)) * longint'($signed(eb)));
                    e_hi = prod[63:32];
                    e_lo = prod[31:0];
                    op   = 1'b0;
                end else if (x_to) begin
                    op = 1'b0;
                end else if (!wr_set && p >= 2 && mul_ready) begin
                    wr_set = 1'b1;
                    wr_at  = cyc + 1;
                end
            end else begin
                if (mthi) e_hi = wdata;
                if (mtlo) e_lo = wdata;
                if (start_mult) begin
                    op = 1'b1; acc = cyc; wr_set = 1'b0; ea = rs_val; eb = rt_val;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        rs_val = a; rt_val = b; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, seen;
        bit done;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_hi", 64'(hi), 64'd0);

        // Simultaneous moves, then mfhi priority over mflo.
        wdata = 32'h55; mthi = 1'b1; mtlo = 1'b1; tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mv_both_hi", 64'(hi), 64'h55);
        chk("mv_both_lo", 64'(lo), 64'h55);
        wdata = 32'h66; mtlo = 1'b1; tick(); mtlo = 1'b0;
        mfhi = 1'b1; mflo = 1'b1; #1;
        chk("rd_prio", 64'(hilo_rdata), 64'h55);
        mfhi = 1'b0; #1;
        chk("rd_lo", 64'(hilo_rdata), 64'h66);
        mflo = 1'b0;

        // 7 * -3 with a slow multiplier.
        mm_lat = 34; snap = do_cnt;
        issue(32'd7, 32'hFFFF_FFFD);
        wait_idle("t1_done", 100);
        chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t1_lo", 64'(lo), 64'hFFFF_FFEB);
        tick();
        chk("t1_do_once", 64'(do_cnt - snap), 64'd1);

        // Stalled mflo returns the fresh product.
        mm_lat = 3;
        issue(32'd100, 32'd5);
        mflo = 1'b1; #1;
        chk("t2_stall", 64'(stall), 64'd1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!stall) done = 1'b1;
        end
        chk("t2_release", 64'(done), 64'd1);
        chk("t2_rdata", 64'(hilo_rdata), 64'd500);
        mflo = 1'b0;
        tick();

        // Timeout; stale ready from previous op is present during LAUNCH.
        mm_lat = 0; snap = to_cnt;
        issue(32'd9, 32'd9);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (timeout_err) done = 1'b1;
        end
        chk("t3_pulse", 64'(done), 64'd1);
        tick();
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_hi", 64'(hi), 64'd0);
        chk("t3_lo", 64'(lo), 64'd500);
        chk("t3_to_once", 64'(to_cnt - snap), 64'd1);

        // Overflow product with exception flag.
        mm_lat = 2; mm_exc = 1'b1; snap = ovf_cnt;
        issue(32'h7FFF_FFFF, 32'd2);
        wait_idle("t4_done", 20);
        mm_exc = 1'b0;
        tick();
        chk("t4_hi", 64'(hi), 64'd0);
        chk("t4_lo", 64'(lo), 64'hFFFF_FFFE);
        chk("t4_ovf_cnt", 64'(ovf_cnt - snap), OvfEn ? 64'd1 : 64'd0);

        // Reset during WAIT, then a fresh 3 * 4.
        mm_lat = 20;
        issue(32'd5, 32'd6);
        tick(); tick(); tick();
        rst_n = 1'b0; #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_hi", 64'(hi), 64'd0);
        chk("t5_lo", 64'(lo), 64'd0);
        chk("t5_opa", 64'(mul_A), 64'd0);
        tick();
        rst_n = 1'b1;
        mm_lat = 2;
        issue(32'd3, 32'd4);
        wait_idle("t5_done", 20);
        chk("t5_lo12", 64'(lo), 64'd12);

        // Back-to-back MULTs with a move between; both held while busy.
        mm_lat = 3;
        issue(32'd2, 32'd3);
        wdata = 32'hDEAD_BEEF; mthi = 1'b1;
        rs_val = 32'd10; rt_val = 32'hFFFF_FFF5; start_mult = 1'b1; #1;
        seen = 0; done = 1'b0;
        if (stall) seen++;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!stall) done = 1'b1; else seen++;
        end
        chk("t6_release", 64'(done), 64'd1);
        chk("t6_was_stalled", 64'(seen > 0), 64'd1);
        chk("t6_first", 64'(lo), 64'd6);
        tick();
        mthi = 1'b0; start_mult = 1'b0;
        chk("t6_move", 64'(hi), 64'hDEAD_BEEF);
        chk("t6_accepted", 64'(busy), 64'd1);
        wait_idle("t6_done", 20);
        chk("t6_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t6_lo", 64'(lo), 64'hFFFF_FF92);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
